// File: rtl/alu_sequencer.sv
// ALU control sequencer: decodes ALU_Op/funct, runs an IDLE->EXEC->DONE handshake.
// Optional macro ALU_SEQ_MULDIV_MULTICYCLE_EN gives multiply/divide multi-cycle EXEC latency.
module alu_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_alu_op,
  input  logic [5:0] req_funct,
  input  logic       abort,
  output logic [3:0] alu_control,
  output logic       alu_en,
  output logic       stall,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_n;
  logic       illegal_q;
  logic       accept;
  logic       exec_last;
  logic [3:0] dec_code;

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul
    $error("alu_sequencer: MUL_CYCLES must be 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div
    $error("alu_sequencer: DIV_CYCLES must be 1..15");
  end

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] funct);
    logic [3:0] code;
    case (op)
      2'b00:   code = 4'b0001;
      2'b01:   code = 4'b0010;
      2'b10:   code = 4'b1100;
      default: code = (funct <= 6'd9) ? (funct[3:0] + 4'd3) : 4'b0000;
    endcase
    return code;
  endfunction

  assign dec_code  = decode(req_alu_op, req_funct);
  assign req_ready = (state == IDLE) && !abort;
  assign accept    = req_valid && req_ready;

`ifdef ALU_SEQ_MULDIV_MULTICYCLE_EN
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
  localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

  logic [3:0] cnt;

  function automatic logic [3:0] lat_last(input logic [3:0] code);
    logic [3:0] last;
    case (code)
      4'b0101: last = MUL_LAST;
      4'b0110: last = DIV_LAST;
      default: last = 4'd0;
    endcase
    return last;
  endfunction

  // Counter holds remaining EXEC cycles after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (accept) begin
      cnt <= lat_last(dec_code);
    end else if (state == EXEC && abort) begin
      cnt <= 4'd0;
    end else if (state == EXEC && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign exec_last = (cnt == 4'd0);
`else
  assign exec_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_control <= 4'b0000;
      illegal_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        alu_control <= dec_code;
        illegal_q   <= (dec_code == 4'b0000);
      end
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (accept) state_n = (dec_code == 4'b0000) ? DONE : EXEC;
      end
      EXEC: begin
        if (abort)          state_n = IDLE;
        else if (exec_last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs decode straight from state so reset clears them without a clock edge.
  assign alu_en  = (state == EXEC);
  assign stall   = (state != IDLE);
  assign done    = (state == DONE) && !abort;
  assign illegal = (state == DONE) && !abort && illegal_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer: decode table plus abort, reset and
// back-to-back sequences. Expected latencies follow ALU_SEQ_MULDIV_MULTICYCLE_EN.
module tb_alu_sequencer;

`ifdef ALU_SEQ_MULDIV_MULTICYCLE_EN
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;
`else
  localparam int MUL_LAT = 1;
  localparam int DIV_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_alu_op;
  logic [5:0] req_funct;
  logic       abort;
  logic [3:0] alu_control;
  logic       alu_en;
  logic       stall;
  logic       done;
  logic       illegal;

  int checks = 0;
  int errors = 0;

  alu_sequencer #(.MUL_CYCLES(4), .DIV_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_funct(req_funct), .abort(abort),
    .alu_control(alu_control), .alu_en(alu_en), .stall(stall),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] code;
    int         lat;
    logic       ill;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    int en_cnt;
    int guard;
    @(negedge clk);
    chk("ready_before", req_ready, 1);
    req_valid  = 1'b1;
    req_alu_op = v.op;
    req_funct  = v.funct;
    step();
    req_valid  = 1'b0;
    req_alu_op = ~v.op;
    req_funct  = ~v.funct;
    chk("alu_control", alu_control, v.code);
    chk("stall_busy", stall, 1);
    en_cnt = 0;
    guard  = 0;
    while (!done && guard < 40) begin
      if (alu_en) en_cnt++;
      step();
      guard++;
    end
    chk("done_seen", done, 1);
    chk("exec_cycles", en_cnt, v.lat);
    chk("illegal", illegal, v.ill);
    chk("alu_en_in_done", alu_en, 0);
    step();
    chk("done_one_cycle", done, 0);
    chk("stall_idle", stall, 0);
    chk("ready_after", req_ready, 1);
    chk("alu_control_hold", alu_control, v.code);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{2'b00, 6'b000000, 4'b0001, 1, 1'b0};
    vecs[1]  = '{2'b00, 6'b111111, 4'b0001, 1, 1'b0};
    vecs[2]  = '{2'b01, 6'b000101, 4'b0010, 1, 1'b0};
    vecs[3]  = '{2'b10, 6'b000011, 4'b1100, 1, 1'b0};
    vecs[4]  = '{2'b11, 6'b000000, 4'b0011, 1, 1'b0};
    vecs[5]  = '{2'b11, 6'b000001, 4'b0100, 1, 1'b0};
    vecs[6]  = '{2'b11, 6'b000010, 4'b0101, MUL_LAT, 1'b0};
    vecs[7]  = '{2'b11, 6'b000011, 4'b0110, DIV_LAT, 1'b0};
    vecs[8]  = '{2'b11, 6'b000100, 4'b0111, 1, 1'b0};
    vecs[9]  = '{2'b11, 6'b000101, 4'b1000, 1, 1'b0};
    vecs[10] = '{2'b11, 6'b000110, 4'b1001, 1, 1'b0};
    vecs[11] = '{2'b11, 6'b000111, 4'b1010, 1, 1'b0};
    vecs[12] = '{2'b11, 6'b001000, 4'b1011, 1, 1'b0};
    vecs[13] = '{2'b11, 6'b001001, 4'b1100, 1, 1'b0};
    vecs[14] = '{2'b11, 6'b001010, 4'b0000, 0, 1'b1};
    vecs[15] = '{2'b11, 6'b111111, 4'b0000, 0, 1'b1};

    rst_n = 1'b0; req_valid = 1'b0; req_alu_op = 2'b00; req_funct = 6'd0; abort = 1'b0;
    #1;
    chk("rst_alu_control", alu_control, 0);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 16; i++) run_op(vecs[i]);

    // Abort a multiply in its second cycle.
    @(negedge clk);
    req_valid = 1'b1; req_alu_op = 2'b11; req_funct = 6'b000010;
    step();
    req_valid = 1'b0;
    chk("abort_code", alu_control, 4'b0101);
    step();
    abort = 1'b1;
    #1;
    chk("abort_done_suppressed", done, 0);
    chk("abort_illegal_suppressed", illegal, 0);
    chk("abort_ready_low", req_ready, 0);
    step();
    chk("abort_idle", stall, 0);
    chk("abort_no_done", done, 0);
    abort = 1'b0;
    #1;
    chk("abort_ready_back", req_ready, 1);

    // Abort held in IDLE blocks acceptance.
    @(negedge clk);
    abort = 1'b1; req_valid = 1'b1; req_alu_op = 2'b01;
    #1;
    chk("abort_idle_ready", req_ready, 0);
    step();
    chk("abort_idle_no_accept", stall, 0);
    chk("abort_idle_code_kept", alu_control, 4'b0101);
    abort = 1'b0; req_valid = 1'b0;

    // Asynchronous reset mid-EXEC of a divide, then acceptance on first edge after release.
    @(negedge clk);
    req_valid = 1'b1; req_alu_op = 2'b11; req_funct = 6'b000011;
    step();
    req_alu_op = 2'b00; req_funct = 6'd0;
    chk("rst_mid_busy", stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_alu_control", alu_control, 0);
    chk("rst_mid_alu_en", alu_en, 0);
    chk("rst_mid_stall", stall, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_illegal", illegal, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    req_valid = 1'b0;
    chk("post_rst_accept_code", alu_control, 4'b0001);
    chk("post_rst_accept_en", alu_en, 1);
    step();
    chk("post_rst_done", done, 1);
    step();

    // Back-to-back with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_alu_op = 2'b00; req_funct = 6'd0;
    step();
    req_alu_op = 2'b11; req_funct = 6'b000100;
    chk("b2b_exec_ready", req_ready, 0);
    chk("b2b_exec_en", alu_en, 1);
    step();
    chk("b2b_done", done, 1);
    chk("b2b_done_ready", req_ready, 0);
    chk("b2b_hold_code", alu_control, 4'b0001);
    step();
    chk("b2b_idle_ready", req_ready, 1);
    chk("b2b_idle_code", alu_control, 4'b0001);
    step();
    req_valid = 1'b0;
    chk("b2b_second_code", alu_control, 4'b0111);
    chk("b2b_second_en", alu_en, 1);
    step();
    chk("b2b_second_done", done, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 4: EXEC cycles for multiply (funct 000010); legal range 1-15.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 8: EXEC cycles for divide (funct 000011); legal range 1-15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: an operation request is present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the sequencer accepts the request this cycle.
REQ-007 The block SHALL have port req_alu_op, input, 2 bits: ALU_Op from main control.
REQ-008 The block SHALL have port req_funct, input, 6 bits: instruction funct field.
REQ-009 The block SHALL have port abort, input, 1 bit: synchronous flush of the in-flight operation.
REQ-010 The block SHALL have port alu_control, output, 4 bits: registered ALU control code.
REQ-011 The block SHALL have port alu_en, output, 1 bit: ALU evaluate enable.
REQ-012 The block SHALL have port stall, output, 1 bit: pipeline hold request.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-014 The block SHALL have port illegal, output, 1 bit: one-cycle pulse, coincident with done, for undecodable requests.

Function
REQ-015 Decode SHALL be: ALU_Op 00->0001, 01->0010, 10->1100; ALU_Op 11 with funct 000000-001001 -> 0011,0100,0101,0110,0111,1000,1001,1010,1011,1100 respectively; any other funct -> 0000.
REQ-016 The FSM SHALL have states IDLE, EXEC, DONE; req_ready = (state==IDLE) && !abort.
REQ-017 On req_valid && req_ready, the block SHALL register the decoded code into alu_control and enter EXEC, with cycle counter loaded to latency-1.
REQ-018 Latency SHALL be 1 EXEC cycle for all legal codes except 0101 (MUL_CYCLES) and 0110 (DIV_CYCLES).
REQ-019 In EXEC: alu_en=1; counter==0 -> DONE next edge, else decrement.
REQ-020 In DONE: done=1 for exactly one cycle; return to IDLE next edge; no new request accepted in DONE.
REQ-021 A decoded code of 0000 SHALL go IDLE->DONE directly with illegal=1 in DONE; alu_en never asserted.
REQ-022 stall SHALL equal (state != IDLE).
REQ-023 alu_control SHALL hold its value from acceptance until the next acceptance.
REQ-024 abort in EXEC or DONE SHALL return to IDLE on the next edge with done and illegal suppressed that cycle; abort in IDLE SHALL block acceptance only.
REQ-025 Inputs req_alu_op/req_funct SHALL be ignored outside the acceptance cycle.

Reset
REQ-026 rst_n low SHALL immediately force state=IDLE, counter=0, alu_control=0000, alu_en=0, done=0, illegal=0, stall=0; reset mid-EXEC discards the operation without a done pulse.
REQ-027 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Configuration
REQ-028 With ALU_SEQ_MULDIV_MULTICYCLE_EN defined, REQ-018 applies as written.
REQ-029 Without ALU_SEQ_MULDIV_MULTICYCLE_EN, every legal code SHALL take exactly 1 EXEC cycle, MUL_CYCLES/DIV_CYCLES SHALL be ignored, and the counter SHALL not be instantiated.

Verification
REQ-030 Scenario: ALU_Op=00 accepted at edge T -> alu_control=0001, alu_en high T..T+1, done high T+1..T+2, req_ready high again at T+2.
REQ-031 Scenario: ALU_Op=11, funct=000011, DIV_CYCLES=8, macro defined -> alu_en high 8 cycles, alu_control=0110, done one cycle later; macro undefined -> alu_en 1 cycle.
REQ-032 Scenario: ALU_Op=11, funct=111111 -> alu_control=0000, alu_en never high, done=1 and illegal=1 in the same cycle, one cycle after acceptance.
REQ-033 Scenario: multiply in flight, abort asserted at 2nd EXEC cycle -> IDLE next edge, no done pulse, req_ready=1 when abort drops.
REQ-034 Scenario: rst_n pulled low mid-EXEC between clock edges -> all outputs reach reset values without a clock edge; request with req_valid held high accepted on first edge after release.
REQ-035 Scenario: back-to-back requests with req_valid held high -> req_ready low in EXEC/DONE, second request accepted exactly in the cycle after done.
